// File: rtl/eth_pkg.sv
// Shared Ethernet definitions: transmit FSM states and framing/CRC constants.
package eth_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPre,
    StSfd,
    StData,
    StPad,
    StFcs,
    StDrain,
    StGap
  } tx_state_e;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam int unsigned PREAMBLE_LEN  = 7;

endpackage

// File: rtl/eth_crc32_byte.sv
// Combinational reflected CRC-32 update for one byte (LSB-first, as sent on the wire).
module eth_crc32_byte
  import eth_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  always_comb begin
    crc_o = crc_i ^ {24'h000000, data_i};
    for (int i = 0; i < 8; i++) begin
      crc_o = crc_o[0] ? ((crc_o >> 1) ^ CRC32_POLY) : (crc_o >> 1);
    end
  end

endmodule

// File: rtl/gmii_tx_scheduler.sv
// Two-source GMII transmit framer: round-robin per frame, preamble/SFD, padding, FCS,
// inter-packet gap, and error signalling for underrun and oversize frames.
module gmii_tx_scheduler
  import eth_pkg::*;
#(
  parameter int unsigned MIN_LEN = 60,
  parameter int unsigned MAX_LEN = 1514,
  parameter int unsigned IFG     = 12
) (
  input  logic        gmii_tx_clk,
  input  logic        gmii_tx_rst,
  input  logic [7:0]  s0_tdata,
  input  logic        s0_tvalid,
  input  logic        s0_tlast,
  output logic        s0_tready,
  input  logic [7:0]  s1_tdata,
  input  logic        s1_tvalid,
  input  logic        s1_tlast,
  output logic        s1_tready,
  output logic [7:0]  gmii_tx_data,
  output logic        gmii_tx_en,
  output logic        gmii_tx_er,
  output logic [1:0]  grant,
  output logic [15:0] frames_ok,
  output logic [15:0] frames_err
);

  tx_state_e   state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        last_s1_q, last_s1_d;
  logic [15:0] cnt_q, cnt_d;
  logic [10:0] byte_cnt_q, byte_cnt_d;
  logic [31:0] crc_q, crc_d;
  logic        err_pend_q, err_pend_d;
  logic [7:0]  data_q, data_d;
  logic        en_q, en_d;
  logic        er_q, er_d;
  logic [15:0] frames_ok_q, frames_ok_d;
  logic [15:0] frames_err_q, frames_err_d;

  logic [7:0]  src_data;
  logic        src_valid;
  logic        src_last;
  logic        take;
  logic [10:0] byte_cnt_inc;
  logic [7:0]  crc_byte;
  logic [31:0] crc_nxt;
  logic [31:0] fcs;
  logic        pick_s1;

  assign src_data  = grant_q[1] ? s1_tdata  : s0_tdata;
  assign src_valid = grant_q[1] ? s1_tvalid : s0_tvalid;
  assign src_last  = grant_q[1] ? s1_tlast  : s0_tlast;

  // The source is drained from the cycle SFD is on the wire, through DATA and DRAIN.
  assign take      = (state_q == StSfd) || (state_q == StData) || (state_q == StDrain);
  assign s0_tready = take & grant_q[0];
  assign s1_tready = take & grant_q[1];

  assign byte_cnt_inc = (byte_cnt_q == 11'h7FF) ? byte_cnt_q : byte_cnt_q + 11'd1;
  assign crc_byte     = (state_q == StPad) ? 8'h00 : src_data;
  assign fcs          = ~crc_q;
  assign pick_s1      = (s0_tvalid && s1_tvalid) ? ~last_s1_q : s1_tvalid;

  eth_crc32_byte u_crc (
    .crc_i  (crc_q),
    .data_i (crc_byte),
    .crc_o  (crc_nxt)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_s1_d    = last_s1_q;
    cnt_d        = cnt_q;
    byte_cnt_d   = byte_cnt_q;
    crc_d        = crc_q;
    err_pend_d   = err_pend_q;
    data_d       = 8'h00;
    en_d         = 1'b0;
    er_d         = 1'b0;
    frames_ok_d  = frames_ok_q;
    frames_err_d = frames_err_q;

    case (state_q)
      StIdle: begin
        if (s0_tvalid || s1_tvalid) begin
          grant_d    = pick_s1 ? 2'b10 : 2'b01;
          last_s1_d  = pick_s1;
          state_d    = StPre;
          cnt_d      = '0;
          byte_cnt_d = '0;
          crc_d      = CRC32_INIT;
          err_pend_d = 1'b0;
          data_d     = PREAMBLE_BYTE;
          en_d       = 1'b1;
        end
      end

      // The first preamble byte is launched from IDLE, so PRE launches the rest plus SFD.
      StPre: begin
        en_d = 1'b1;
        if (cnt_q == 16'(PREAMBLE_LEN - 1)) begin
          data_d  = SFD_BYTE;
          state_d = StSfd;
        end else begin
          data_d = PREAMBLE_BYTE;
          cnt_d  = cnt_q + 16'd1;
        end
      end

      StSfd, StData: begin
        en_d = 1'b1;
        if (src_valid) begin
          data_d     = src_data;
          crc_d      = crc_nxt;
          byte_cnt_d = byte_cnt_inc;
          state_d    = StData;
          if (src_last) begin
            cnt_d   = '0;
            state_d = (32'(byte_cnt_inc) + 32'd1 <= MIN_LEN) ? StPad : StFcs;
          end else if (32'(byte_cnt_inc) == MAX_LEN) begin
            // Last legal byte still goes out cleanly; the error byte follows from DRAIN.
            err_pend_d   = 1'b1;
            state_d      = StDrain;
            frames_err_d = frames_err_q + 16'd1;
          end
        end else begin
          er_d         = 1'b1;
          state_d      = StDrain;
          frames_err_d = frames_err_q + 16'd1;
        end
      end

      StPad: begin
        en_d       = 1'b1;
        crc_d      = crc_nxt;
        byte_cnt_d = byte_cnt_inc;
        if (32'(byte_cnt_inc) == MIN_LEN) begin
          cnt_d   = '0;
          state_d = StFcs;
        end
      end

      StFcs: begin
        en_d = 1'b1;
        unique case (cnt_q[1:0])
          2'd0: data_d = fcs[7:0];
          2'd1: data_d = fcs[15:8];
          2'd2: data_d = fcs[23:16];
          2'd3: data_d = fcs[31:24];
        endcase
        if (cnt_q[1:0] == 2'd3) begin
          cnt_d       = '0;
          state_d     = StGap;
          frames_ok_d = frames_ok_q + 16'd1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      StDrain: begin
        if (err_pend_q) begin
          en_d       = 1'b1;
          er_d       = 1'b1;
          err_pend_d = 1'b0;
        end
        if (src_valid && src_last) begin
          cnt_d   = '0;
          state_d = StGap;
        end
      end

      StGap: begin
        if (cnt_q == 16'(IFG - 1)) begin
          grant_d = 2'b00;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge gmii_tx_clk or posedge gmii_tx_rst) begin
    if (gmii_tx_rst) begin
      state_q      <= StIdle;
      grant_q      <= 2'b00;
      last_s1_q    <= 1'b1;
      cnt_q        <= '0;
      byte_cnt_q   <= '0;
      crc_q        <= CRC32_INIT;
      err_pend_q   <= 1'b0;
      data_q       <= 8'h00;
      en_q         <= 1'b0;
      er_q         <= 1'b0;
      frames_ok_q  <= '0;
      frames_err_q <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_s1_q    <= last_s1_d;
      cnt_q        <= cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      crc_q        <= crc_d;
      err_pend_q   <= err_pend_d;
      data_q       <= data_d;
      en_q         <= en_d;
      er_q         <= er_d;
      frames_ok_q  <= frames_ok_d;
      frames_err_q <= frames_err_d;
    end
  end

  assign gmii_tx_data = data_q;
  assign gmii_tx_en   = en_q;
  assign gmii_tx_er   = er_q;
  assign grant        = grant_q;
  assign frames_ok    = frames_ok_q;
  assign frames_err   = frames_err_q;

endmodule

// File: tb/tb_gmii_tx_scheduler.sv
// Randomised scoreboard bench for gmii_tx_scheduler with a frame-level reference model.
module tb_gmii_tx_scheduler;

  localparam int unsigned MIN_LEN = 60;
  localparam int unsigned MAX_LEN = 100;
  localparam int unsigned IFG     = 12;
  localparam int          NO_UR   = 100000;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  drv_data  [2];
  logic        drv_valid [2];
  logic        drv_last  [2];
  logic        s0_tready, s1_tready;
  logic [7:0]  gmii_tx_data;
  logic        gmii_tx_en, gmii_tx_er;
  logic [1:0]  grant;
  logic [15:0] frames_ok, frames_err;

  always #4 clk = ~clk;

  gmii_tx_scheduler #(
    .MIN_LEN (MIN_LEN),
    .MAX_LEN (MAX_LEN),
    .IFG     (IFG)
  ) dut (
    .gmii_tx_clk  (clk),
    .gmii_tx_rst  (rst),
    .s0_tdata     (drv_data[0]),
    .s0_tvalid    (drv_valid[0]),
    .s0_tlast     (drv_last[0]),
    .s0_tready    (s0_tready),
    .s1_tdata     (drv_data[1]),
    .s1_tvalid    (drv_valid[1]),
    .s1_tlast     (drv_last[1]),
    .s1_tready    (s1_tready),
    .gmii_tx_data (gmii_tx_data),
    .gmii_tx_en   (gmii_tx_en),
    .gmii_tx_er   (gmii_tx_er),
    .grant        (grant),
    .frames_ok    (frames_ok),
    .frames_err   (frames_err)
  );

  int checks   = 0;
  int failures = 0;

  // Expected wire images per source: {er, data} per en-high cycle.
  logic [8:0] exp_b0[$], exp_b1[$];
  int         exp_l0[$], exp_l1[$];
  bit         exp_k0[$], exp_k1[$];

  bit abort_drv = 1'b0;
  bit phase2    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] crc32(input logic [7:0] b[$]);
    logic [31:0] c = 32'hFFFFFFFF;
    foreach (b[i]) begin
      c = c ^ {24'h0, b[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  task automatic push_expected(input int src, input logic [7:0] p[$], input int ur);
    logic [8:0]  w[$];
    logic [7:0]  body[$];
    logic [31:0] fcs;
    int          e = -1;
    bit          ok;
    for (int i = 0; i < 7; i++) w.push_back(9'h055);
    w.push_back(9'h0D5);
    if (ur < p.size()) e = ur;
    if (p.size() > MAX_LEN && (e < 0 || e >= int'(MAX_LEN))) e = MAX_LEN;
    if (e >= 0) begin
      for (int i = 0; i < e; i++) w.push_back({1'b0, p[i]});
      w.push_back(9'h100);
      ok = 1'b0;
    end else begin
      body = p;
      while (body.size() < MIN_LEN) body.push_back(8'h00);
      foreach (body[i]) w.push_back({1'b0, body[i]});
      fcs = ~crc32(body);
      for (int i = 0; i < 4; i++) w.push_back({1'b0, fcs[8*i +: 8]});
      ok = 1'b1;
    end
    if (src == 0) begin
      exp_l0.push_back(w.size()); exp_k0.push_back(ok);
      foreach (w[i]) exp_b0.push_back(w[i]);
    end else begin
      exp_l1.push_back(w.size()); exp_k1.push_back(ok);
      foreach (w[i]) exp_b1.push_back(w[i]);
    end
  endtask

  function automatic logic rdy(input int src);
    return (src == 0) ? s0_tready : s1_tready;
  endfunction

  // Present a frame; ur = index of the byte before which tvalid drops for two cycles.
  task automatic drive_frame(input int src, input logic [7:0] p[$], input int ur);
    int n;
    push_expected(src, p, ur);
    for (int i = 0; i < p.size(); i++) begin
      if (abort_drv) break;
      if (i == ur) begin
        drv_valid[src] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
      end
      drv_data[src]  = p[i];
      drv_last[src]  = (i == p.size() - 1);
      drv_valid[src] = 1'b1;
      n = 0;
      forever begin
        @(negedge clk);
        if (abort_drv || rdy(src)) break;
        n++;
        if (n > 4000) begin
          $display("FAIL handshake_timeout src=%0d byte=%0d", src, i);
          $fatal(1, "handshake timeout");
        end
      end
      if (abort_drv) break;
      @(posedge clk);
      #1;
    end
    drv_valid[src] = 1'b0;
    drv_last[src]  = 1'b0;
  endtask

  // Monitor state
  logic [8:0] cap[$];
  bit in_frame = 1'b0, have_prev = 1'b0, prev_ok = 1'b0, first_after_rst = 1'b1;
  int cur_src = 0, prev_src = 0, first_src = -1, idle = 0, ok_cnt = 0, err_cnt = 0;
  int p2_frames = 0;

  task automatic finish_frame();
    int         l;
    bit         k;
    logic [8:0] e;
    int         bad = -1;
    logic [8:0] bad_act = '0, bad_exp = '0;
    checks++;
    if ((cur_src == 0 && exp_l0.size() == 0) || (cur_src == 1 && exp_l1.size() == 0)) begin
      failures++;
      $display("FAIL unexpected_frame src=%0d len=%0d required=none", cur_src, cap.size());
      return;
    end
    l = (cur_src == 0) ? exp_l0.pop_front() : exp_l1.pop_front();
    k = (cur_src == 0) ? exp_k0.pop_front() : exp_k1.pop_front();
    for (int i = 0; i < l; i++) begin
      e = (cur_src == 0) ? exp_b0.pop_front() : exp_b1.pop_front();
      if (bad < 0 && (i >= cap.size() || cap[i] !== e)) begin
        bad = i; bad_exp = e; bad_act = (i < cap.size()) ? cap[i] : 9'h1FF;
      end
    end
    if (bad < 0 && cap.size() != l) bad = l;
    if (bad >= 0) begin
      failures++;
      $display("FAIL frame_content src=%0d idx=%0d actual=0x%0h required=0x%0h len=%0d/%0d",
               cur_src, bad, bad_act, bad_exp, cap.size(), l);
    end
    if (k) ok_cnt++; else err_cnt++;
    checks++;
    if (frames_ok !== 16'(ok_cnt) || frames_err !== 16'(err_cnt)) begin
      failures++;
      $display("FAIL counters actual=%0d/%0d required=%0d/%0d", frames_ok, frames_err,
               ok_cnt, err_cnt);
    end
    prev_ok = k;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        cap.delete(); in_frame = 0; have_prev = 0; idle = 0;
        ok_cnt = 0; err_cnt = 0; first_after_rst = 1;
      end else begin
        checks++;
        if ((s0_tready && grant != 2'b01) || (s1_tready && grant != 2'b10) ||
            (!gmii_tx_en && gmii_tx_er)) begin
          failures++;
          $display("FAIL ready_grant actual=%b%b/%b/%b required=ready_only_to_owner",
                   s1_tready, s0_tready, grant, gmii_tx_er);
        end
        if (gmii_tx_en) begin
          if (!in_frame) begin
            in_frame = 1;
            cur_src  = grant[1] ? 1 : 0;
            check("grant_onehot", 32'(grant == 2'b01 || grant == 2'b10), 1);
            if (have_prev) begin
              checks++;
              if (idle < int'(IFG) || (phase2 && p2_frames > 0 && prev_ok && idle != int'(IFG))) begin
                failures++;
                $display("FAIL ifg actual=%0d required=%0d", idle, IFG);
              end
            end
            if (phase2 && p2_frames > 0) check("rr_alternate", 32'(cur_src != prev_src), 1);
            if (phase2) p2_frames++;
            if (first_after_rst) begin first_src = cur_src; first_after_rst = 0; end
          end
          if (cap.size() == 6) check("tready_before_sfd", 32'(rdy(cur_src)), 0);
          if (cap.size() == 7) check("tready_at_sfd", 32'(rdy(cur_src)), 1);
          cap.push_back({gmii_tx_er, gmii_tx_data});
        end else begin
          if (in_frame) begin
            finish_frame();
            cap.delete(); in_frame = 0; have_prev = 1; prev_src = cur_src; idle = 0;
          end
          idle++;
        end
      end
    end
  end

  task automatic wait_quiet();
    int n = 0;
    while ((exp_l0.size() + exp_l1.size() != 0 || in_frame) && n < 20000) begin
      @(posedge clk);
      n++;
    end
    check("drain_timeout", 32'(n >= 20000), 0);
    repeat (IFG + 4) @(posedge clk);
    #1;
  endtask

  function automatic void rand_frame(output logic [7:0] p[$], input int len);
    p.delete();
    for (int i = 0; i < len; i++) p.push_back(8'($urandom));
  endfunction

  int d_src [10] = '{0, 0, 1, 1, 0, 0, 1, 0, 1, 0};
  int d_len [10] = '{9, 10, 40, 64, 120, 100, 101, 60, 59, 61};
  int d_ur  [10] = '{NO_UR, NO_UR, 20, NO_UR, NO_UR, NO_UR, NO_UR, NO_UR, NO_UR, NO_UR};

  initial begin
    logic [7:0] p[$], q[$];
    string s = "123456789";
    int len, ur, n;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin drv_data[i] = 0; drv_valid[i] = 0; drv_last[i] = 0; end
    repeat (3) @(posedge clk);
    #1;
    check("reset_wire", {gmii_tx_en, gmii_tx_er, gmii_tx_data}, 0);
    check("reset_grant_ready", {grant, s0_tready, s1_tready}, 0);
    check("reset_counters", {frames_ok, frames_err}, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk) #1;

    for (int f = 0; f < 10; f++) begin
      rand_frame(p, d_len[f]);
      if (f == 0) for (int i = 0; i < 9; i++) p[i] = s[i];
      if (f == 0) begin
        fork
          drive_frame(0, p, NO_UR);
          begin
            @(posedge clk);
            #2;
            check("start_latency", {gmii_tx_en, gmii_tx_data}, {1'b1, 8'h55});
          end
        join
      end else begin
        drive_frame(d_src[f], p, d_ur[f]);
      end
    end

    for (int f = 0; f < 16; f++) begin
      len = $urandom_range(1, 110);
      ur  = (len > 1 && $urandom_range(0, 5) == 0) ? $urandom_range(1, len - 1) : NO_UR;
      rand_frame(p, len);
      drive_frame($urandom_range(0, 1), p, ur);
    end
    wait_quiet();

    phase2 = 1'b1;
    fork
      begin
        logic [7:0] a[$];
        for (int i = 0; i < 4; i++) begin rand_frame(a, 64); drive_frame(0, a, NO_UR); end
      end
      begin
        logic [7:0] b[$];
        for (int i = 0; i < 4; i++) begin rand_frame(b, 64); drive_frame(1, b, NO_UR); end
      end
    join
    wait_quiet();
    phase2 = 1'b0;
    check("phase2_frames", 32'(p2_frames), 8);

    rand_frame(p, 80);
    fork
      drive_frame(0, p, NO_UR);
      begin
        n = 0;
        while (!gmii_tx_en && n < 200) begin @(posedge clk); n++; end
        repeat (30) @(posedge clk);
        #3;
        abort_drv = 1'b1;
        rst       = 1'b1;
        #1;
        check("async_reset_wire", {gmii_tx_en, gmii_tx_er, gmii_tx_data}, 0);
        check("async_reset_grant_ready", {grant, s0_tready, s1_tready}, 0);
        check("async_reset_counters", {frames_ok, frames_err}, 0);
      end
    join
    repeat (3) @(posedge clk);
    exp_b0.delete(); exp_l0.delete(); exp_k0.delete();
    exp_b1.delete(); exp_l1.delete(); exp_k1.delete();
    @(negedge clk);
    abort_drv = 1'b0;
    rst       = 1'b0;
    @(posedge clk) #1;

    rand_frame(p, 70);
    rand_frame(q, 30);
    fork
      drive_frame(0, p, NO_UR);
      drive_frame(1, q, NO_UR);
    join
    wait_quiet();
    check("rr_after_reset", 32'(first_src), 0);
    check("ok_after_reset", {16'h0, frames_ok}, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
